// File: rtl/icap_pkg.sv
// icap_pkg: ICAP command words, stream constants, FSM encoding and word helpers
package icap_pkg;
  localparam logic [15:0] ICAP_DUMMY     = 16'hFFFF;
  localparam logic [15:0] ICAP_SYNC0     = 16'hAA99;
  localparam logic [15:0] ICAP_SYNC1     = 16'h5566;
  localparam logic [15:0] ICAP_WR_GEN1   = 16'h3261;
  localparam logic [15:0] ICAP_WR_GEN2   = 16'h3281;
  localparam logic [15:0] ICAP_WR_GEN3   = 16'h32A1;
  localparam logic [15:0] ICAP_WR_GEN4   = 16'h32C1;
  localparam logic [15:0] ICAP_WR_CMD    = 16'h30A1;
  localparam logic [15:0] ICAP_CMD_IPROG = 16'h000E;
  localparam logic [15:0] ICAP_NOOP      = 16'h2000;
  localparam logic [7:0]  ICAP_IPROG_OP  = 8'h03;
  localparam int          ICAP_STREAM_LEN = 14;
  localparam logic [3:0]  ICAP_LAST_IDX  = 4'(ICAP_STREAM_LEN - 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WORD, S_GAP, S_DONE} state_t;
  // Unswapped IPROG stream word at position idx; out-of-range indices fall back to NOOP
  function automatic logic [15:0] icap_word(input logic [3:0] idx, input logic [23:0] a, input logic [23:0] alt);
    case (idx)
      4'd0:    return ICAP_DUMMY;
      4'd1:    return ICAP_SYNC0;
      4'd2:    return ICAP_SYNC1;
      4'd3:    return ICAP_WR_GEN1;
      4'd4:    return a[15:0];
      4'd5:    return ICAP_WR_GEN2;
      4'd6:    return {ICAP_IPROG_OP, a[23:16]};
      4'd7:    return ICAP_WR_GEN3;
      4'd8:    return alt[15:0];
      4'd9:    return ICAP_WR_GEN4;
      4'd10:   return {ICAP_IPROG_OP, alt[23:16]};
      4'd11:   return ICAP_WR_CMD;
      4'd12:   return ICAP_CMD_IPROG;
      default: return ICAP_NOOP;
    endcase
  endfunction
  // ICAP expects each byte bit-reversed relative to the bitstream byte order
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
    return r;
  endfunction
endpackage

// File: rtl/reboot_trigger_qual.sv
// reboot_trigger_qual: synchronizes the reboot request and accepts a qualified falling edge
module reboot_trigger_qual #(
  parameter int QUAL_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic trigger,
  output logic accept
);
  logic [1:0] sync_q, sync_d;
  logic       seen_q, seen_d;
  logic [3:0] low_q, low_d;
  assign accept = seen_q && (low_q >= 4'(QUAL_CYCLES));
  // High sample arms the flag; consecutive lows after it count up to the qualify threshold
  always_comb begin
    sync_d = {sync_q[0], trigger};
    seen_d = seen_q;
    low_d  = low_q;
    if (!enable || accept) begin
      seen_d = 1'b0;
      low_d  = 4'd0;
    end else if (sync_q[1]) begin
      seen_d = 1'b1;
      low_d  = 4'd0;
    end else if (seen_q && low_q != 4'hF) begin
      low_d  = low_q + 4'd1;
    end
  end
  // Synchronizer and qualifier state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      seen_q <= 1'b0;
      low_q  <= 4'd0;
    end else begin
      sync_q <= sync_d;
      seen_q <= seen_d;
      low_q  <= low_d;
    end
  end
endmodule

// File: rtl/icap_reboot_sequencer.sv
// icap_reboot_sequencer: qualifies a reboot request and streams the ICAP IPROG command words
module icap_reboot_sequencer
  import icap_pkg::*;
#(
  parameter int          QUAL_CYCLES = 3,
  parameter int          GAP_CYCLES  = 0,
  parameter logic [23:0] ALT_ADDR    = 24'h0,
  parameter bit          SWAP_BITS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trigger,
  input  logic [23:0] boot_addr,
  output logic        busy,
  output logic        done,
  output logic        icap_ce_n,
  output logic        icap_we_n,
  output logic [15:0] icap_din
);
  logic        accept;
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, idx_nx;
  logic [2:0]  gap_q, gap_d;
  logic [23:0] addr_q, addr_d;
  logic        busy_q, busy_d, done_q, done_d, ce_n_q, ce_n_d, we_n_q, we_n_d;
  logic [15:0] din_q, din_d, raw_nx, word_nx;
  logic        last, gap_end;

  reboot_trigger_qual #(.QUAL_CYCLES(QUAL_CYCLES)) u_qual (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .trigger(trigger),
    .accept (accept)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign icap_ce_n = ce_n_q;
  assign icap_we_n = we_n_q;
  assign icap_din  = din_q;

  // Next-state and registered-output logic; outputs change one edge after the state decision
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ce_n_d  = ce_n_q;
    we_n_d  = we_n_q;
    din_d   = din_q;
    idx_nx  = (state_q == S_LOAD) ? 4'd0 : idx_q + 4'd1;
    raw_nx  = icap_word(idx_nx, addr_q, ALT_ADDR);
    word_nx = SWAP_BITS ? byte_swap(raw_nx) : raw_nx;
    last    = idx_q == ICAP_LAST_IDX;
    gap_end = gap_q == 3'(GAP_CYCLES - 1);
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_LOAD;
        busy_d  = 1'b1;
        we_n_d  = 1'b0;
      end
      S_LOAD: begin
        addr_d  = boot_addr;
        state_d = S_WORD;
        ce_n_d  = 1'b0;
        din_d   = word_nx;
        idx_d   = idx_nx;
      end
      S_WORD: begin
        ce_n_d = 1'b1;
        gap_d  = 3'd0;
        if (GAP_CYCLES != 0) begin
          state_d = S_GAP;
        end else if (last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ce_n_d = 1'b0;
          din_d  = word_nx;
          idx_d  = idx_nx;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 3'd1;
        if (gap_end && last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gap_end) begin
          state_d = S_WORD;
          ce_n_d  = 1'b0;
          din_d   = word_nx;
          idx_d   = idx_nx;
        end
      end
      S_DONE:  we_n_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and ICAP pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      gap_q   <= 3'd0;
      addr_q  <= 24'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      din_q   <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      din_q   <= din_d;
    end
  end
endmodule

// File: tb/tb_icap_reboot_sequencer.sv
// tb_icap_reboot_sequencer: scoreboard bench for the ICAP reboot sequencer
module tb_icap_reboot_sequencer;
  localparam logic [23:0] ALT1 = 24'h123456;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst0 = 1'b1, en0 = 1'b1, trg0 = 1'b0;
  logic [23:0] addr0 = 24'h058000;
  logic busy0, done0, ce0, we0;
  logic [15:0] din0;
  logic rst1 = 1'b1, en1 = 1'b1, trg1 = 1'b0;
  logic [23:0] addr1 = 24'hABCDEF;
  logic busy1, done1, ce1, we1;
  logic [15:0] din1;

  icap_reboot_sequencer #(.QUAL_CYCLES(3), .GAP_CYCLES(0), .ALT_ADDR(24'h0), .SWAP_BITS(1'b1)) dut0 (
    .clk(clk), .rst(rst0), .enable(en0), .trigger(trg0), .boot_addr(addr0),
    .busy(busy0), .done(done0), .icap_ce_n(ce0), .icap_we_n(we0), .icap_din(din0));
  icap_reboot_sequencer #(.QUAL_CYCLES(3), .GAP_CYCLES(2), .ALT_ADDR(ALT1), .SWAP_BITS(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .trigger(trg1), .boot_addr(addr1),
    .busy(busy1), .done(done1), .icap_ce_n(ce1), .icap_we_n(we1), .icap_din(din1));

  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rev8(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7 - i];
      r[8 + i] = w[15 - i];
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_word(input int i, input logic [23:0] a, input logic [23:0] alt, input bit swap);
    logic [15:0] t[14];
    t = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281, {8'h03, a[23:16]},
          16'h32A1, alt[15:0], 16'h32C1, {8'h03, alt[23:16]}, 16'h30A1, 16'h000E, 16'h2000};
    return swap ? rev8(t[i]) : t[i];
  endfunction

  logic [15:0] q0[$], q1[$];
  int ce_cnt0 = 0, ce_cnt1 = 0, busy_cyc0 = 0;
  int load_t0 = 0, done_t0 = 0, load_t1 = 0, done_t1 = 0, last_ce1 = -1;
  logic bp0 = 1'b0, dp0 = 1'b0, bp1 = 1'b0, dp1 = 1'b0;

  always @(negedge clk) begin
    if (busy0 && !bp0) load_t0 = cyc;
    if (done0 && !dp0) done_t0 = cyc;
    bp0 = busy0;
    dp0 = done0;
    if (busy0) busy_cyc0++;
    if (ce0 === 1'b0) begin
      ce_cnt0++;
      check("ce0_we_low", we0, 0);
      if (q0.size() == 0) check("ce0_unexpected_word", q0.size(), 1);
      else check("ce0_word", din0, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (busy1 && !bp1) load_t1 = cyc;
    if (done1 && !dp1) done_t1 = cyc;
    bp1 = busy1;
    dp1 = done1;
    if (ce1 === 1'b0) begin
      ce_cnt1++;
      check("ce1_we_low", we1, 0);
      if (last_ce1 >= 0) check("ce1_spacing", cyc - last_ce1, 3);
      last_ce1 = cyc;
      if (q1.size() == 0) check("ce1_unexpected_word", q1.size(), 1);
      else check("ce1_word", din1, q1.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse0(input int hi);
    trg0 = 1'b1;
    tick(hi);
    trg0 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget);
    int k = 0;
    while (!(which ? done1 : done0) && k < budget) begin
      tick(1);
      k++;
    end
    check(which ? "done1_reached" : "done0_reached", which ? done1 : done0, 1);
  endtask

  int base;
  initial begin
    tick(3);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_ce_n", ce0, 1);
    check("rst_we_n", we0, 1);
    check("rst_din", din0, 16'hFFFF);
    check("rst_busy1", busy1, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick(2);
    // enable low: pulse must be ignored
    en0 = 1'b0;
    pulse0(5);
    tick(15);
    check("disabled_busy_cycles", busy_cyc0, 0);
    check("disabled_ce_count", ce_cnt0, 0);
    en0 = 1'b1;
    tick(2);
    // short low glitch: two lows then re-raised, must not qualify
    trg0 = 1'b1;
    tick(1);
    trg0 = 1'b0;
    tick(2);
    trg0 = 1'b1;
    tick(10);
    check("glitch_busy_cycles", busy_cyc0, 0);
    check("glitch_ce_count", ce_cnt0, 0);
    // clean falling edge -> full stream
    for (int i = 0; i < 14; i++) q0.push_back(ref_word(i, addr0, 24'h0, 1'b1));
    trg0 = 1'b0;
    wait_done(1'b0, 60);
    check("s1_ce_count", ce_cnt0, 14);
    check("s1_queue_empty", q0.size(), 0);
    check("s1_busy_after", busy0, 0);
    check("s1_load_to_done", done_t0 - load_t0, 15);
    tick(2);
    check("s1_we_n_idle", we0, 1);
    check("s1_ce_n_idle", ce0, 1);
    // reset during word 7
    rst0 = 1'b1;
    tick(1);
    rst0 = 1'b0;
    check("rst2_done_clear", done0, 0);
    base = ce_cnt0;
    for (int i = 0; i < 14; i++) q0.push_back(ref_word(i, addr0, 24'h0, 1'b1));
    pulse0(5);
    for (int k = 0; k < 60 && ce_cnt0 - base < 8; k++) tick(1);
    check("s4_reached_word7", ce_cnt0 - base, 8);
    rst0 = 1'b1;
    q0.delete();
    tick(1);
    check("s4_ce_n", ce0, 1);
    check("s4_we_n", we0, 1);
    check("s4_busy", busy0, 0);
    check("s4_din", din0, 16'hFFFF);
    rst0 = 1'b0;
    tick(2);
    // restart from word 0, with a trigger pulse during the stream
    addr0 = 24'h3C00A5;
    base = ce_cnt0;
    for (int i = 0; i < 14; i++) q0.push_back(ref_word(i, addr0, 24'h0, 1'b1));
    pulse0(5);
    for (int k = 0; k < 20 && !busy0; k++) tick(1);
    check("s5_busy_started", busy0, 1);
    trg0 = 1'b1;
    tick(4);
    trg0 = 1'b0;
    wait_done(1'b0, 60);
    check("s5_ce_count", ce_cnt0 - base, 14);
    check("s5_queue_empty", q0.size(), 0);
    check("s5_load_to_done", done_t0 - load_t0, 15);
    pulse0(5);
    tick(30);
    check("s5_ce_count_after", ce_cnt0 - base, 14);
    check("s5_done_sticky", done0, 1);
    check("s5_busy_after", busy0, 0);
    // gapped, unswapped instance
    for (int i = 0; i < 14; i++) q1.push_back(ref_word(i, addr1, ALT1, 1'b0));
    trg1 = 1'b1;
    tick(3);
    trg1 = 1'b0;
    wait_done(1'b1, 120);
    check("g_ce_count", ce_cnt1, 14);
    check("g_queue_empty", q1.size(), 0);
    check("g_load_to_done", done_t1 - load_t1, 43);
    tick(3);
    check("g_we_n_idle", we1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
